// File: rtl/dmem_bus_responder.sv
// Purpose : data-memory responder; one load/store at a time over valid/ready, word array with byte strobes.
// Latency : response valid WAIT_CYCLES+1 edges after the request-accept edge.
// Backpr. : req_ready low while a transaction is outstanding; response held stable until resp_ready.
//
// Ports:
//   clk, rst                  clock and asynchronous active-high reset
//   req_valid / req_ready     request handshake (req_ready decoded from state only)
//   req_we, req_addr,         1 = store / 0 = load, byte address,
//   req_wdata, req_wstrb      store data and byte-lane enables (bit i -> bits [8i+7:8i])
//   resp_valid / resp_ready   response handshake
//   resp_rdata, resp_err      load data (0 for stores and faults), address fault flag
module dmem_bus_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int          AW      = $clog2(DEPTH_WORDS);
    // Byte span of the array, one bit wider than the address so that the
    // range compare stays correct even for a full 4 GiB window.
    localparam logic [32:0] LP_SPAN = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  LP_WAIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic        r_resp_err;

    // Storage is deliberately left out of reset.
    logic [31:0] r_mem [DEPTH_WORDS];

    logic [31:0]   w_off;
    logic          w_below;
    logic          w_oor;
    logic          w_mis;
    logic          w_err;
    logic [AW-1:0] w_idx;
    logic          w_access;
    logic          w_commit;
    logic [31:0]   w_rd_word;
    logic          w_accept;

    // ------------------------------------------------------------------
    // Address decode on the latched request
    // ------------------------------------------------------------------
    always_comb begin
        w_off   = r_addr - BASE_ADDR;
        w_below = (r_addr < BASE_ADDR);
        w_oor   = ({1'b0, w_off} >= LP_SPAN);
        w_mis   = (r_addr[1:0] != 2'b00);
        w_err   = w_below | w_oor | w_mis;
        w_idx   = w_off[AW+1:2];
    end

    // The access edge is the last BUSY edge; the state register is forced to
    // IDLE asynchronously by rst, so an interrupted store never commits.
    assign w_access  = (r_state == BUSY) && (r_cnt == 4'd0);
    assign w_commit  = w_access && r_we && !w_err;
    assign w_rd_word = r_mem[w_idx];
    assign w_accept  = req_valid && (r_state == IDLE);

    // ------------------------------------------------------------------
    // Byte-strobed write port
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (r_wstrb[i]) begin
                    r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with registered response outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= 4'd0;
            r_we         <= 1'b0;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            r_wstrb      <= 4'd0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'd0;
            r_resp_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_we    <= req_we;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_wstrb <= req_wstrb;
                        r_cnt   <= LP_WAIT;
                        r_state <= BUSY;
                    end
                end

                BUSY: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= w_err;
                        // Faults and stores both return zero data.
                        r_resp_rdata <= (w_err || r_we) ? 32'd0 : w_rd_word;
                        r_state      <= RESP;
                    end
                end

                RESP: begin
                    // Data and error stay on the bus after the handshake;
                    // only resp_valid qualifies them.
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= IDLE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign req_ready  = (r_state == IDLE);
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_dmem_bus_responder.sv
// Purpose : scoreboard bench for dmem_bus_responder (WAIT_CYCLES=2 and WAIT_CYCLES=0 instances).
// Latency : expects response after WAIT_CYCLES+1 edges from accept.
// Backpr. : exercises held responses under resp_ready low.
module tb_dmem_bus_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_ready;
    int          sel;

    logic        rdy_a, rv_a, err_a;
    logic [31:0] rd_a;
    logic        rdy_b, rv_b, err_b;
    logic [31:0] rd_b;

    logic        w_req_ready, w_resp_valid, w_resp_err;
    logic [31:0] w_rdata;

    int n_vec = 0;
    int n_mis = 0;

    logic [32:0] exp_q[$];
    logic [31:0] mdl[int];

    always #5 clk = ~clk;

    dmem_bus_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid && (sel == 0)),
        .req_ready  (rdy_a),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .resp_valid (rv_a),
        .resp_ready (resp_ready && (sel == 0)),
        .resp_rdata (rd_a),
        .resp_err   (err_a)
    );

    dmem_bus_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) u_dut0 (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid && (sel == 1)),
        .req_ready  (rdy_b),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .resp_valid (rv_b),
        .resp_ready (resp_ready && (sel == 1)),
        .resp_rdata (rd_b),
        .resp_err   (err_b)
    );

    assign w_req_ready  = (sel == 1) ? rdy_b : rdy_a;
    assign w_resp_valid = (sel == 1) ? rv_b  : rv_a;
    assign w_resp_err   = (sel == 1) ? err_b : err_a;
    assign w_rdata      = (sel == 1) ? rd_b  : rd_a;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete transaction: model update, drive, latency check,
    // optional 5-cycle backpressure, scoreboard compare, handshake.
    task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input bit bp);
        logic        e;
        logic [31:0] exp_rd;
        logic [31:0] old;
        logic [31:0] first;
        logic [32:0] ex;
        int          key;
        int          k;
        bit          ok;

        e      = (addr[1:0] != 2'b00) || (addr >= 32'h1000);
        key    = sel * 4096 + int'(addr[11:2]);
        exp_rd = 32'd0;
        if (!e) begin
            old = mdl.exists(key) ? mdl[key] : 32'd0;
            if (we) begin
                for (int i = 0; i < 4; i++)
                    if (strb[i]) old[8*i +: 8] = wdata[8*i +: 8];
                mdl[key] = old;
            end else begin
                exp_rd = old;
            end
        end
        exp_q.push_back({e, exp_rd});

        @(negedge clk);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (w_req_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) chk("req_ready_timeout", 32'd0, 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_wstrb = strb;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = ~we;
        req_addr  = 32'hFFFF_FFFF;
        req_wdata = 32'h5A5A_5A5A;
        req_wstrb = 4'hF;
        chk("busy_req_ready", 32'(w_req_ready), 32'd0);

        k  = 0;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (w_resp_valid) begin ok = 1'b1; break; end
            @(posedge clk);
            #1;
            k++;
        end
        if (!ok) begin
            chk("resp_timeout", 32'd0, 32'd1);
            ex = exp_q.pop_front();
            return;
        end
        chk("latency", 32'(k), (sel == 1) ? 32'd1 : 32'd3);

        if (bp) begin
            first = w_rdata;
            for (int i = 0; i < 5; i++) begin
                @(posedge clk);
                #1;
                chk("bp_valid", 32'(w_resp_valid), 32'd1);
                chk("bp_rdata", w_rdata, first);
                chk("bp_req_ready", 32'(w_req_ready), 32'd0);
            end
        end

        ex = exp_q.pop_front();
        chk("rdata", w_rdata, ex[31:0]);
        chk("err", 32'(w_resp_err), 32'(ex[32]));

        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        chk("hs_resp_valid", 32'(w_resp_valid), 32'd0);
        chk("hs_req_ready", 32'(w_req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        rst        = 1'b1;
        sel        = 0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        req_wstrb  = 4'd0;
        resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", 32'(w_req_ready), 32'd1);
        chk("rst_resp_valid", 32'(w_resp_valid), 32'd0);
        chk("rst_rdata", w_rdata, 32'd0);
        chk("rst_err", 32'(w_resp_err), 32'd0);

        // resp_ready without a pending response does nothing
        resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        resp_ready = 1'b0;
        chk("idle_resp_valid", 32'(w_resp_valid), 32'd0);
        chk("idle_req_ready", 32'(w_req_ready), 32'd1);

        // Store/load and byte strobes
        send(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
        send(1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
        send(1'b1, 32'h10, 32'h11223344, 4'b0101, 1'b0);
        send(1'b0, 32'h10, 32'h0, 4'hF, 1'b1);
        chk("strobe_literal", w_rdata, 32'hDE22BE44);
        send(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 1'b0);
        send(1'b0, 32'h10, 32'h0, 4'h0, 1'b0);

        // Faults
        send(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 1'b0);
        send(1'b0, 32'h12, 32'h0, 4'h0, 1'b0);
        send(1'b1, 32'h1000, 32'h0BADBAD0, 4'hF, 1'b0);
        send(1'b1, 32'h3, 32'h0BADBAD0, 4'hF, 1'b0);
        send(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);

        // Random full then partial stores, read back
        for (int i = 0; i < 6; i++) begin
            a = 32'h100 + 32'(4 * $urandom_range(0, 15));
            send(1'b1, a, $urandom, 4'hF, 1'b0);
            send(1'b1, a, $urandom, 4'($urandom_range(0, 15)), 1'b0);
            send(1'b0, a, 32'h0, 4'h0, 1'b0);
        end

        // Reset in the middle of a store
        send(1'b1, 32'h20, 32'hAAAA5555, 4'hF, 1'b0);
        send(1'b0, 32'h20, 32'h0, 4'h0, 1'b0);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'h12345678;
        req_wstrb = 4'hF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_resp_valid", 32'(w_resp_valid), 32'd0);
        chk("mid_rst_req_ready", 32'(w_req_ready), 32'd1);
        chk("mid_rst_rdata", w_rdata, 32'd0);
        chk("mid_rst_err", 32'(w_resp_err), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            chk("post_rst_no_resp", 32'(w_resp_valid), 32'd0);
        end
        send(1'b0, 32'h20, 32'h0, 4'h0, 1'b0);

        // Zero-wait-state instance
        sel = 1;
        send(1'b1, 32'h30, 32'h01020304, 4'hF, 1'b0);
        send(1'b0, 32'h30, 32'h0, 4'h0, 1'b1);
        send(1'b0, 32'h31, 32'h0, 4'h0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
